regfile_reader: RTL and testbench

REGFILE_READER -- requirements
Module: regfile_reader

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rd_mux.sv | 38 +++
 rtl/regfile_reader.sv | 81 ++++++++
 tb/tb_regfile_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file read path.
// Optional same-cycle write bypass: REGFILE_READER_BYPASS_EN.
package regfile_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rd_state_t;

endpackage

// File: rtl/regfile_rd_mux.sv
// Combinational register select for one read port, zero-register aware.
// With REGFILE_READER_BYPASS_EN a same-cycle write forwards its data.
module regfile_rd_mux
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
    input  logic [ADDR_WIDTH-1:0]                      addr,
    input  logic                                       wr_en,
    input  logic [ADDR_WIDTH-1:0]                      wr_addr,
    input  logic [DATA_WIDTH-1:0]                      wr_data,
    output logic [DATA_WIDTH-1:0]                      data
);

    always_comb begin
        data = '0;
        if (addr != '0) begin
`ifdef REGFILE_READER_BYPASS_EN
            if (wr_en && (wr_addr == addr)) begin
                data = wr_data;
            end else begin
                data = regs[addr];
            end
`else
            data = regs[addr];
`endif
        end
    end

`ifndef REGFILE_READER_BYPASS_EN
    // Write-side inputs only matter when forwarding is built in.
    logic unused_bypass;
    assign unused_bypass = ^{wr_en, wr_addr, wr_data};
`endif

endmodule

// File: rtl/regfile_reader.sv
// Register file with a dual-port registered read and valid/ready hold.
// Define REGFILE_READER_BYPASS_EN to forward same-cycle writes to reads.
module regfile_reader
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    input  logic                  READ,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    output logic                  READ_ACK,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
    rd_state_t                        state;
    logic [DATA_WIDTH-1:0]            rd_data1;
    logic [DATA_WIDTH-1:0]            rd_data2;

    // Writes are independent of read backpressure.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            regs <= '0;
        end else if (WRITE && (ADDR_W != '0)) begin
            regs[ADDR_W] <= DATA_W;
        end
    end

    regfile_rd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mux1 (
        .regs    (regs),
        .addr    (ADDR_R1),
        .wr_en   (WRITE),
        .wr_addr (ADDR_W),
        .wr_data (DATA_W),
        .data    (rd_data1)
    );

    regfile_rd_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mux2 (
        .regs    (regs),
        .addr    (ADDR_R2),
        .wr_en   (WRITE),
        .wr_addr (ADDR_W),
        .wr_data (DATA_W),
        .data    (rd_data2)
    );

    assign READ_ACK = RST & READ & ((state == IDLE) | RREADY);
    assign RVALID   = (state == HOLD);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            DATA_R1 <= '0;
            DATA_R2 <= '0;
        end else if (READ_ACK) begin
            state   <= HOLD;
            DATA_R1 <= rd_data1;
            DATA_R2 <= rd_data2;
        end else if ((state == HOLD) && RREADY) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_regfile_reader.sv
// Self-checking bench for regfile_reader: directed scenarios plus random traffic.
// Honours REGFILE_READER_BYPASS_EN for the forwarding expectations.
module tb_regfile_reader;

    logic        CLK;
    logic        RST;
    logic        WRITE;
    logic [4:0]  ADDR_W;
    logic [31:0] DATA_W;
    logic        READ;
    logic [4:0]  ADDR_R1;
    logic [4:0]  ADDR_R2;
    logic        READ_ACK;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] DATA_R1;
    logic [31:0] DATA_R2;

    int tests_run;
    int tests_failed;

    // Reference model: plain memory plus the currently presented result.
    logic [31:0] m_mem [32];
    logic        m_valid;
    logic [31:0] m_d1;
    logic [31:0] m_d2;

    regfile_reader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WRITE    (WRITE),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ     (READ),
        .ADDR_R1  (ADDR_R1),
        .ADDR_R2  (ADDR_R2),
        .READ_ACK (READ_ACK),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .DATA_R1  (DATA_R1),
        .DATA_R2  (DATA_R2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] model_rd(input logic [4:0] a, input logic wr,
                                             input logic [4:0] aw, input logic [31:0] dw);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_READER_BYPASS_EN
        if (wr && aw == a) return dw;
`endif
        return m_mem[a];
    endfunction

    // Drives one cycle from a falling edge, advances the model, returns at next falling edge.
    task automatic step(input logic rst, input logic wr, input logic [4:0] aw,
                        input logic [31:0] dw, input logic rd, input logic [4:0] a1,
                        input logic [4:0] a2, input logic rr,
                        output logic ack_got, output logic ack_exp);
        logic [31:0] v1, v2;
        RST = rst; WRITE = wr; ADDR_W = aw; DATA_W = dw;
        READ = rd; ADDR_R1 = a1; ADDR_R2 = a2; RREADY = rr;
        #1;
        ack_got = READ_ACK;
        ack_exp = rst && rd && (!m_valid || rr);
        v1 = model_rd(a1, wr, aw, dw);
        v2 = model_rd(a2, wr, aw, dw);
        @(posedge CLK);
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
            m_valid = 1'b0; m_d1 = 32'd0; m_d2 = 32'd0;
        end else begin
            if (ack_exp) begin
                m_valid = 1'b1; m_d1 = v1; m_d2 = v2;
            end else if (m_valid && rr) begin
                m_valid = 1'b0;
            end
            if (wr && aw != 5'd0) m_mem[aw] = dw;
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        logic ag, ae;
        step(0, 1, 5'd4, 32'hFFFF_FFFF, 1, 5'd4, 5'd4, 1, ag, ae);
        tests_run++;
        if (ag !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ack: got %b want 0", ag);
        end
        step(0, 0, 5'd0, 32'd0, 1, 5'd0, 5'd0, 0, ag, ae);
        tests_run++;
        if ({RVALID, DATA_R1, DATA_R2} !== 65'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b d1=%h d2=%h want 0", RVALID, DATA_R1, DATA_R2);
        end
    endtask

    task automatic test_zero_read();
        logic ag, ae;
        step(1, 0, 5'd0, 32'd0, 1, 5'd3, 5'd0, 0, ag, ae);
        tests_run++;
        if (ag !== 1'b1) begin
            tests_failed++; $display("FAIL zero_ack: got %b want 1", ag);
        end
        tests_run++;
        if (RVALID !== 1'b1 || DATA_R1 !== 32'd0 || DATA_R2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL zero_read: got v=%b d1=%h d2=%h want 1/0/0", RVALID, DATA_R1, DATA_R2);
        end
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 1, ag, ae);
        tests_run++;
        if (RVALID !== 1'b0) begin
            tests_failed++; $display("FAIL zero_drain: got v=%b want 0", RVALID);
        end
    endtask

    task automatic test_write_read();
        logic ag, ae;
        step(1, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 5'd0, 0, ag, ae);
        step(1, 0, 5'd0, 32'd0, 1, 5'd5, 5'd5, 0, ag, ae);
        tests_run++;
        if (RVALID !== 1'b1 || DATA_R1 !== 32'hDEAD_BEEF || DATA_R2 !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL same_addr: got v=%b d1=%h d2=%h want 1/deadbeef/deadbeef",
                     RVALID, DATA_R1, DATA_R2);
        end
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 1, ag, ae);
        tests_run++;
        if (RVALID !== 1'b0 || DATA_R1 !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL keep_after_drain: got v=%b d1=%h want 0/deadbeef", RVALID, DATA_R1);
        end
    endtask

    task automatic test_reg0_write();
        logic ag, ae;
        step(1, 1, 5'd0, 32'h0000_1234, 0, 5'd0, 5'd0, 0, ag, ae);
        step(1, 0, 5'd0, 32'd0, 1, 5'd0, 5'd5, 0, ag, ae);
        tests_run++;
        if (DATA_R1 !== 32'd0 || DATA_R2 !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL reg0_write: got d1=%h d2=%h want 0/deadbeef", DATA_R1, DATA_R2);
        end
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 1, ag, ae);
    endtask

    task automatic test_backpressure();
        logic ag, ae;
        step(1, 0, 5'd0, 32'd0, 1, 5'd5, 5'd3, 0, ag, ae);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 5'd5, 32'h0000_AAAA, 1, 5'd5, 5'd3, 0, ag, ae);
            tests_run++;
            if (ag !== 1'b0 || RVALID !== 1'b1 || DATA_R1 !== 32'hDEAD_BEEF || DATA_R2 !== 32'd0) begin
                tests_failed++;
                $display("FAIL hold_%0d: got ack=%b v=%b d1=%h d2=%h want 0/1/deadbeef/0",
                         i, ag, RVALID, DATA_R1, DATA_R2);
            end
        end
        step(1, 0, 5'd0, 32'd0, 1, 5'd5, 5'd5, 1, ag, ae);
        tests_run++;
        if (ag !== 1'b1 || RVALID !== 1'b1 || DATA_R1 !== 32'h0000_AAAA || DATA_R2 !== 32'h0000_AAAA) begin
            tests_failed++;
            $display("FAIL b2b_accept: got ack=%b v=%b d1=%h d2=%h want 1/1/aaaa/aaaa",
                     ag, RVALID, DATA_R1, DATA_R2);
        end
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 1, ag, ae);
    endtask

    task automatic test_bypass();
        logic ag, ae;
        logic [31:0] exp;
`ifdef REGFILE_READER_BYPASS_EN
        exp = 32'h55;
`else
        exp = 32'h11;
`endif
        step(1, 1, 5'd7, 32'h11, 0, 5'd0, 5'd0, 0, ag, ae);
        step(1, 1, 5'd7, 32'h55, 1, 5'd7, 5'd0, 0, ag, ae);
        tests_run++;
        if (DATA_R1 !== exp || DATA_R2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL bypass: got d1=%h d2=%h want %h/0", DATA_R1, DATA_R2, exp);
        end
        step(1, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 1, ag, ae);
        tests_run++;
        if (DATA_R1 !== 32'h55 || DATA_R2 !== 32'h55) begin
            tests_failed++;
            $display("FAIL after_write: got d1=%h d2=%h want 55/55", DATA_R1, DATA_R2);
        end
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 1, ag, ae);
    endtask

    task automatic test_reset_inflight();
        logic ag, ae;
        step(1, 1, 5'd9, 32'hCAFE_F00D, 0, 5'd0, 5'd0, 0, ag, ae);
        step(1, 0, 5'd0, 32'd0, 1, 5'd9, 5'd7, 0, ag, ae);
        tests_run++;
        if (RVALID !== 1'b1 || DATA_R1 !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL pre_reset: got v=%b d1=%h want 1/cafef00d", RVALID, DATA_R1);
        end
        step(0, 1, 5'd9, 32'h1111_2222, 1, 5'd9, 5'd9, 1, ag, ae);
        tests_run++;
        if (ag !== 1'b0 || RVALID !== 1'b0 || DATA_R1 !== 32'd0 || DATA_R2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_inflight: got ack=%b v=%b d1=%h d2=%h want 0/0/0/0",
                     ag, RVALID, DATA_R1, DATA_R2);
        end
        step(1, 0, 5'd0, 32'd0, 1, 5'd9, 5'd7, 0, ag, ae);
        tests_run++;
        if (RVALID !== 1'b1 || DATA_R1 !== 32'd0 || DATA_R2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL cleared_regs: got v=%b d1=%h d2=%h want 1/0/0", RVALID, DATA_R1, DATA_R2);
        end
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 1, ag, ae);
    endtask

    task automatic test_random();
        logic ag, ae, rst, wr, rd, rr;
        logic [4:0] aw, a1, a2;
        logic [31:0] dw;
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) != 0);
            wr  = ($urandom_range(0, 1) == 1);
            rd  = ($urandom_range(0, 2) != 0);
            rr  = ($urandom_range(0, 2) != 0);
            aw  = 5'($urandom_range(0, 7));
            a1  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a2  = 5'($urandom_range(0, 7));
            dw  = $urandom;
            step(rst, wr, aw, dw, rd, a1, a2, rr, ag, ae);
            tests_run++;
            if (ag !== ae || RVALID !== m_valid || DATA_R1 !== m_d1 || DATA_R2 !== m_d2) begin
                tests_failed++;
                if (errs < 10)
                    $display("FAIL random_%0d: got ack=%b v=%b d1=%h d2=%h want %b/%b/%h/%h",
                             i, ag, RVALID, DATA_R1, DATA_R2, ae, m_valid, m_d1, m_d2);
                errs++;
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        m_valid = 1'b0; m_d1 = 32'd0; m_d2 = 32'd0;
        RST = 0; WRITE = 0; ADDR_W = 0; DATA_W = 0;
        READ = 0; ADDR_R1 = 0; ADDR_R2 = 0; RREADY = 0;
        @(negedge CLK);
        test_reset();
        test_zero_read();
        test_write_read();
        test_reg0_write();
        test_backpressure();
        test_bypass();
        test_reset_inflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
